pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline (fetch, decd, exec, memw, wrbk).
- Generates the operand-forwarding selects for the decode-stage register reads.
- Detects load-use hazards and inserts bubbles; sequences branch flushes.
- Arbitrates the single memory port between instruction fetch and the memw-stage LDR/STR, with a wait-state FSM and a timeout watchdog.

---
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard sequencer
// Forwarding selects, load-use bubbles, branch flush and memory-port arbitration with watchdog.
module pipe_hazard_ctrl #(
  parameter int FLUSH_DEPTH = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       decd_valid,
  input  logic [3:0] decd_rega,
  input  logic [3:0] decd_regb,
  input  logic       decd_usea,
  input  logic       decd_useb,
  input  logic       exec_valid,
  input  logic       exec_wr_en,
  input  logic       exec_is_load,
  input  logic [3:0] exec_wr_reg,
  input  logic       memw_valid,
  input  logic       memw_wr_en,
  input  logic       memw_mem_req,
  input  logic [3:0] memw_wr_reg,
  input  logic       wrbk_valid,
  input  logic       wrbk_wr_en,
  input  logic [3:0] wrbk_wr_reg,
  input  logic       branch_taken,
  input  logic       fetch_req,
  input  logic       mem_ready,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall_front,
  output logic       bubble_exec,
  output logic       flush_front,
  output logic       stall_pipe,
  output logic       mem_grant_data,
  output logic       mem_grant_fetch,
  output logic       mem_timeout_err
);

  typedef enum logic [1:0] {IDLE, DATA_WAIT, FETCH_WAIT} mem_state_t;

  mem_state_t state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic [2:0] flush_cnt;
  logic       timeout_err;
  logic       grant_data, grant_fetch, timeout_hit, stall, flush_active, lu;
  logic       ex_hit_a, ex_hit_b, mw_hit_a, mw_hit_b, wb_hit_a, wb_hit_b;

  function automatic logic [1:0] fwd_select(input logic use_reg, input logic [3:0] rd,
                                            input logic ex_hit, input logic mw_hit,
                                            input logic wb_hit, input logic ex_load);
    if (!use_reg || rd == 4'd15) return 2'd0;
    if (ex_hit)                  return ex_load ? 2'd0 : 2'd1;
    if (mw_hit)                  return 2'd2;
    if (wb_hit)                  return 2'd3;
    return 2'd0;
  endfunction

  assign ex_hit_a = exec_valid && exec_wr_en && (exec_wr_reg == decd_rega);
  assign ex_hit_b = exec_valid && exec_wr_en && (exec_wr_reg == decd_regb);
  assign mw_hit_a = memw_valid && memw_wr_en && (memw_wr_reg == decd_rega);
  assign mw_hit_b = memw_valid && memw_wr_en && (memw_wr_reg == decd_regb);
  assign wb_hit_a = wrbk_valid && wrbk_wr_en && (wrbk_wr_reg == decd_rega);
  assign wb_hit_b = wrbk_valid && wrbk_wr_en && (wrbk_wr_reg == decd_regb);

  assign lu = decd_valid && exec_is_load &&
              ((decd_usea && decd_rega != 4'd15 && ex_hit_a) ||
               (decd_useb && decd_regb != 4'd15 && ex_hit_b));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    grant_data   = 1'b0;
    grant_fetch  = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      IDLE: begin
        wait_cnt_nxt = 8'd0;
        if (memw_mem_req) begin
          grant_data = 1'b1;
          if (!mem_ready) state_nxt = DATA_WAIT;
        end else if (fetch_req) begin
          grant_fetch = 1'b1;
          if (!mem_ready) state_nxt = FETCH_WAIT;
        end
      end
      DATA_WAIT, FETCH_WAIT: begin
        grant_data  = (state == DATA_WAIT);
        grant_fetch = (state == FETCH_WAIT);
        if (mem_ready) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
          // this wait cycle is the MEM_TIMEOUT-th; abort at the edge
          state_nxt    = IDLE;
          wait_cnt_nxt = 8'd0;
          timeout_hit  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall        = (grant_data || grant_fetch) && !mem_ready;
  assign flush_active = !stall && (branch_taken || flush_cnt != 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      flush_cnt   <= 3'd0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_hit) timeout_err <= 1'b1;
      if (!stall) begin
        if (branch_taken)           flush_cnt <= 3'(FLUSH_DEPTH - 1);
        else if (flush_cnt != 3'd0) flush_cnt <= flush_cnt - 3'd1;
      end
    end
  end

  // reset gates the combinational paths so every output reads 0 during reset
  assign fwd_a_sel       = reset ? 2'd0 : fwd_select(decd_usea, decd_rega, ex_hit_a, mw_hit_a, wb_hit_a, exec_is_load);
  assign fwd_b_sel       = reset ? 2'd0 : fwd_select(decd_useb, decd_regb, ex_hit_b, mw_hit_b, wb_hit_b, exec_is_load);
  assign stall_pipe      = !reset && stall;
  assign mem_grant_data  = !reset && grant_data;
  assign mem_grant_fetch = !reset && grant_fetch;
  assign flush_front     = !reset && flush_active;
  assign stall_front     = !reset && !stall && !flush_active && lu;
  assign bubble_exec     = !reset && !stall && !flush_active && lu;
  assign mem_timeout_err = timeout_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
// Directed and random stimulus; expectations come from a behavioural model of the pipeline rules.
module tb_pipe_hazard_ctrl;
  localparam int FLUSH_DEPTH = 2;
  localparam int MEM_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       decd_valid, decd_usea, decd_useb;
  logic [3:0] decd_rega, decd_regb;
  logic       exec_valid, exec_wr_en, exec_is_load;
  logic [3:0] exec_wr_reg;
  logic       memw_valid, memw_wr_en, memw_mem_req;
  logic [3:0] memw_wr_reg;
  logic       wrbk_valid, wrbk_wr_en;
  logic [3:0] wrbk_wr_reg;
  logic       branch_taken, fetch_req, mem_ready;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_front, bubble_exec, flush_front, stall_pipe;
  logic       mem_grant_data, mem_grant_fetch, mem_timeout_err;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, bx, ff, sp, gd, gf, err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // model state: port owner 0=none 1=data 2=fetch
  int owner = 0, waited = 0, flush_left = 0;
  bit err_m = 0;

  pipe_hazard_ctrl #(.FLUSH_DEPTH(FLUSH_DEPTH), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .decd_valid(decd_valid), .decd_rega(decd_rega), .decd_regb(decd_regb),
    .decd_usea(decd_usea), .decd_useb(decd_useb),
    .exec_valid(exec_valid), .exec_wr_en(exec_wr_en), .exec_is_load(exec_is_load),
    .exec_wr_reg(exec_wr_reg),
    .memw_valid(memw_valid), .memw_wr_en(memw_wr_en), .memw_mem_req(memw_mem_req),
    .memw_wr_reg(memw_wr_reg),
    .wrbk_valid(wrbk_valid), .wrbk_wr_en(wrbk_wr_en), .wrbk_wr_reg(wrbk_wr_reg),
    .branch_taken(branch_taken), .fetch_req(fetch_req), .mem_ready(mem_ready),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_front(stall_front), .bubble_exec(bubble_exec), .flush_front(flush_front),
    .stall_pipe(stall_pipe), .mem_grant_data(mem_grant_data),
    .mem_grant_fetch(mem_grant_fetch), .mem_timeout_err(mem_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int ref_fwd(input bit use_reg, input int rd);
    if (!use_reg || rd == 15) return 0;
    if (exec_valid && exec_wr_en && int'(exec_wr_reg) == rd) return exec_is_load ? 0 : 1;
    if (memw_valid && memw_wr_en && int'(memw_wr_reg) == rd) return 2;
    if (wrbk_valid && wrbk_wr_en && int'(wrbk_wr_reg) == rd) return 3;
    return 0;
  endfunction

  function automatic bit ref_lu();
    bit a, b;
    a = decd_usea && decd_rega != 4'd15 && exec_wr_reg == decd_rega;
    b = decd_useb && decd_regb != 4'd15 && exec_wr_reg == decd_regb;
    return decd_valid && exec_valid && exec_is_load && exec_wr_en && (a || b);
  endfunction

  // predict this cycle's outputs from the current inputs, then advance the model one clock
  task automatic cycle();
    exp_t e;
    int   now;
    bit   st;
    e = '0;
    if (reset) begin
      owner = 0; waited = 0; flush_left = 0; err_m = 0;
    end else begin
      now = owner;
      if (now == 0) now = memw_mem_req ? 1 : (fetch_req ? 2 : 0);
      st    = (now != 0) && !mem_ready;
      e.fa  = 2'(ref_fwd(decd_usea, int'(decd_rega)));
      e.fb  = 2'(ref_fwd(decd_useb, int'(decd_regb)));
      e.sp  = st;
      e.gd  = (now == 1);
      e.gf  = (now == 2);
      e.err = err_m;
      e.ff  = !st && (branch_taken || flush_left > 0);
      e.sf  = !st && !e.ff && ref_lu();
      e.bx  = e.sf;
      if (!st) begin
        if (branch_taken)        flush_left = FLUSH_DEPTH - 1;
        else if (flush_left > 0) flush_left--;
      end
      if (st) begin
        if (owner == 0) begin
          owner = now; waited = 0;
        end else begin
          waited++;
          if (waited == MEM_TIMEOUT) begin owner = 0; waited = 0; err_m = 1; end
        end
      end else begin
        owner = 0; waited = 0;
      end
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    decd_valid = 0; decd_usea = 0; decd_useb = 0; decd_rega = 0; decd_regb = 0;
    exec_valid = 0; exec_wr_en = 0; exec_is_load = 0; exec_wr_reg = 0;
    memw_valid = 0; memw_wr_en = 0; memw_mem_req = 0; memw_wr_reg = 0;
    wrbk_valid = 0; wrbk_wr_en = 0; wrbk_wr_reg = 0;
    branch_taken = 0; fetch_req = 0; mem_ready = 0;
  endtask

  function automatic logic [3:0] pick_reg();
    return ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  task automatic rand_inputs(input int ready_pct);
    decd_valid   = 1'($urandom_range(0, 3) != 0);
    decd_usea    = 1'($urandom_range(0, 1));
    decd_useb    = 1'($urandom_range(0, 1));
    decd_rega    = pick_reg();
    decd_regb    = pick_reg();
    exec_valid   = 1'($urandom_range(0, 1));
    exec_wr_en   = 1'($urandom_range(0, 3) != 0);
    exec_is_load = 1'($urandom_range(0, 2) == 0);
    exec_wr_reg  = pick_reg();
    memw_valid   = 1'($urandom_range(0, 1));
    memw_wr_en   = 1'($urandom_range(0, 3) != 0);
    memw_mem_req = 1'($urandom_range(0, 3) == 0);
    memw_wr_reg  = pick_reg();
    wrbk_valid   = 1'($urandom_range(0, 1));
    wrbk_wr_en   = 1'($urandom_range(0, 3) != 0);
    wrbk_wr_reg  = pick_reg();
    branch_taken = 1'($urandom_range(0, 7) == 0);
    fetch_req    = 1'($urandom_range(0, 1));
    mem_ready    = 1'(int'($urandom_range(0, 99)) < ready_pct);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd_a_sel",       int'(fwd_a_sel),       int'(e.fa));
        check("fwd_b_sel",       int'(fwd_b_sel),       int'(e.fb));
        check("stall_front",     int'(stall_front),     int'(e.sf));
        check("bubble_exec",     int'(bubble_exec),     int'(e.bx));
        check("flush_front",     int'(flush_front),     int'(e.ff));
        check("stall_pipe",      int'(stall_pipe),      int'(e.sp));
        check("mem_grant_data",  int'(mem_grant_data),  int'(e.gd));
        check("mem_grant_fetch", int'(mem_grant_fetch), int'(e.gf));
        check("mem_timeout_err", int'(mem_timeout_err), int'(e.err));
      end
    end
  end

  initial begin : stimulus
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin rand_inputs(50); cycle(); end
    clear_inputs();
    reset = 0;
    cycle();

    // forwarding priority and PC exclusion
    decd_valid = 1; decd_usea = 1; decd_rega = 3;
    exec_valid = 1; exec_wr_en = 1; exec_wr_reg = 3;
    memw_valid = 1; memw_wr_en = 1; memw_wr_reg = 3;
    cycle();
    exec_valid = 0; cycle();
    memw_valid = 0; wrbk_valid = 1; wrbk_wr_en = 1; wrbk_wr_reg = 3; cycle();
    decd_rega = 15; cycle();

    // load-use then forward from memw
    clear_inputs();
    decd_valid = 1; decd_useb = 1; decd_regb = 5;
    exec_valid = 1; exec_wr_en = 1; exec_is_load = 1; exec_wr_reg = 5;
    cycle();
    exec_valid = 0; exec_is_load = 0;
    memw_valid = 1; memw_wr_en = 1; memw_wr_reg = 5;
    cycle();

    // data access wins over fetch, three wait states
    clear_inputs();
    memw_mem_req = 1; fetch_req = 1;
    for (int i = 0; i < 3; i++) cycle();
    mem_ready = 1; cycle();
    memw_mem_req = 0; cycle();

    // watchdog timeout, sticky error
    clear_inputs();
    fetch_req = 1;
    for (int i = 0; i < MEM_TIMEOUT + 4; i++) cycle();
    fetch_req = 0;
    for (int i = 0; i < 3; i++) cycle();

    // branch flush suppresses a concurrent load-use hazard; data wait extends the flush
    clear_inputs();
    decd_valid = 1; decd_usea = 1; decd_rega = 2;
    exec_valid = 1; exec_wr_en = 1; exec_is_load = 1; exec_wr_reg = 2;
    branch_taken = 1; cycle();
    branch_taken = 0; cycle(); cycle();
    branch_taken = 1; cycle();
    branch_taken = 0; memw_mem_req = 1; cycle(); cycle();
    mem_ready = 1; cycle();
    memw_mem_req = 0; cycle(); cycle();

    // reset mid-wait clears the grant and the sticky error
    clear_inputs();
    memw_mem_req = 1; cycle(); cycle();
    reset = 1; cycle();
    reset = 0; clear_inputs(); cycle();

    // random phases with differing memory latency
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 150; i++) begin
        rand_inputs((p == 3) ? 3 : 90 - 30 * p);
        reset = ($urandom_range(0, 199) == 0);
        cycle();
      end
    end
    reset = 0;
    clear_inputs();
    cycle();

    @(negedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
